// File: rtl/memory_address_register.sv
// memory_address_register: 32-bit MAR with load, pixel (+1) and row (+IMG_W) address stepping
module memory_address_register #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int IMG_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              inc_en,
  input  logic              row_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] data_addr,
  output logic              addr_wrap
);
  logic [DATA_W-1:0] mar_q, mar_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W:0]   sum;
  logic              step;
  // Row step takes precedence over pixel step; the extra bit catches the wrap carry
  always_comb begin
    step   = row_en | inc_en;
    sum    = {1'b0, mar_q[ADDR_W-1:0]} + (row_en ? (ADDR_W+1)'(IMG_W) : (ADDR_W+1)'(1));
    mar_d  = w_en ? data_in : step ? {mar_q[DATA_W-1:ADDR_W], sum[ADDR_W-1:0]} : mar_q;
    wrap_d = !w_en && step && sum[ADDR_W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mar_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      mar_q  <= mar_d;
      wrap_q <= wrap_d;
    end
  end
  assign data_out  = mar_q;
  assign data_addr = mar_q[ADDR_W-1:0];
  assign addr_wrap = wrap_q;
endmodule

// File: tb/tb_memory_address_register.sv
// tb_memory_address_register: directed vectors, a behavioural reference model and literal pins
module tb_memory_address_register;
  logic        clk = 1'b0;
  logic        rst = 1'b1, w_en = 1'b0, inc_en = 1'b0, row_en = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [11:0] data_addr;
  logic        addr_wrap;
  int          vectors = 0, miscompares = 0;
  logic [31:0] m_val = '0;
  logic        m_wrap = 1'b0, m_valid = 1'b0;

  memory_address_register dut (
    .clk(clk), .rst(rst), .w_en(w_en), .inc_en(inc_en), .row_en(row_en),
    .data_in(data_in), .data_out(data_out), .data_addr(data_addr), .addr_wrap(addr_wrap)
  );

  always #5 clk = ~clk;

  // Reference: address field treated as an integer in [0,4096), stepped and reduced modulo 4096
  always @(posedge clk) begin
    int a, n;
    a = int'(m_val % 4096);
    n = a + (row_en ? 64 : 1);
    if (rst) begin
      m_val <= 0; m_wrap <= 0; m_valid <= 1;
    end else if (w_en) begin
      m_val <= data_in; m_wrap <= 0;
    end else if (row_en || inc_en) begin
      m_val  <= (m_val / 4096) * 4096 + 32'(n % 4096);
      m_wrap <= (n >= 4096);
    end else
      m_wrap <= 0;
  end

  always @(negedge clk) if (m_valid) begin
    vectors++;
    if (data_out !== m_val || data_addr !== m_val[11:0] || addr_wrap !== m_wrap) begin
      miscompares++;
      $display("FAIL model: data_out=%h addr=%h wrap=%b, expected %h %h %b",
               data_out, data_addr, addr_wrap, m_val, m_val[11:0], m_wrap);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic i, input logic rw, input logic [31:0] d);
    rst = r; w_en = w; inc_en = i; row_en = rw; data_in = d;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 32'h0);
    chk("reset_out", data_out, 32'h0);
    chk("reset_addr", 32'(data_addr), 32'h0);
    chk("reset_wrap", 32'(addr_wrap), 32'h0);
    cyc(0, 1, 0, 0, 32'hA5A5A5A5);
    chk("load_out", data_out, 32'hA5A5A5A5);
    chk("load_addr", 32'(data_addr), 32'h5A5);
    cyc(0, 0, 0, 0, 32'h12345678);
    chk("hold_out", data_out, 32'hA5A5A5A5);
    chk("hold_addr", 32'(data_addr), 32'h5A5);
    cyc(0, 1, 0, 0, 32'hABCD0FFE);
    cyc(0, 0, 1, 0, 32'h0);
    chk("inc1_addr", 32'(data_addr), 32'hFFF);
    chk("inc1_wrap", 32'(addr_wrap), 32'h0);
    cyc(0, 0, 1, 0, 32'h0);
    chk("inc2_out", data_out, 32'hABCD0000);
    chk("inc2_addr", 32'(data_addr), 32'h000);
    chk("inc2_wrap", 32'(addr_wrap), 32'h1);
    cyc(0, 0, 0, 0, 32'h0);
    chk("idle_wrap", 32'(addr_wrap), 32'h0);
    cyc(0, 1, 0, 0, 32'h00000010);
    cyc(0, 0, 0, 1, 32'h0);
    chk("row_addr", 32'(data_addr), 32'h050);
    chk("row_nowrap", 32'(addr_wrap), 32'h0);
    cyc(0, 1, 0, 0, 32'h00000FF0);
    cyc(0, 0, 0, 1, 32'h0);
    chk("rowwrap_out", data_out, 32'h00000030);
    chk("rowwrap_wrap", 32'(addr_wrap), 32'h1);
    cyc(0, 1, 0, 0, 32'hDEAD0FC0);
    cyc(0, 0, 0, 1, 32'h0);
    chk("rowexact_out", data_out, 32'hDEAD0000);
    chk("rowexact_wrap", 32'(addr_wrap), 32'h1);
    cyc(0, 1, 1, 1, 32'h00000100);
    chk("prio_load", data_out, 32'h00000100);
    chk("prio_load_wrap", 32'(addr_wrap), 32'h0);
    cyc(0, 0, 1, 1, 32'h0);
    chk("prio_row", 32'(data_addr), 32'h140);
    cyc(0, 1, 0, 0, 32'h00000122);
    cyc(0, 0, 1, 0, 32'h0);
    chk("pre_rst_addr", 32'(data_addr), 32'h123);
    cyc(1, 1, 1, 0, 32'hFFFFFFFF);
    chk("midrst_out", data_out, 32'h0);
    chk("midrst_wrap", 32'(addr_wrap), 32'h0);
    cyc(0, 0, 1, 0, 32'h0);
    chk("post_rst_addr", 32'(data_addr), 32'h001);
    for (int k = 0; k < 40; k++)
      cyc(k % 17 == 16, ($urandom % 5) == 0, 1'($urandom), 1'($urandom), $urandom | 32'h00000F00);
    cyc(0, 0, 0, 0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
